// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants and the hex-to-segment decode table for the seven-segment scanner.
package seven_segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Bit positions inside seg, {a,b,c,d,e,f,g} with a in the MSB.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_timer.sv
// Slot and frame timebase: per-slot counter, digit index, frame counter and blink phase.
module scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64,
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          dead,
  output logic          blink_ph
);

  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          tick;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));
  assign dead = (cnt < CW'(DEAD_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      if (wrap) begin
        idx <= '0;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment driver with double-buffered load, dead time,
// leading-zero suppression and blinking; all pins are registered.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz;
  } disp_buf_t;

  disp_buf_t       in_buf, pend, shadow;
  logic            pend_valid;
  logic [IW-1:0]   idx;
  logic            wrap, dead, blink_ph;

  assign in_buf = '{digits: digits, dp: dp, en: digit_en, blink: blink_mask, lz: lz_suppress};

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (idx),
    .wrap    (wrap),
    .dead    (dead),
    .blink_ph(blink_ph)
  );

  // Shadow only changes on the frame wrap so a frame is never torn. A load on the
  // wrap tick bypasses pending and lands in shadow on the same edge.
  // NOTE: both buffers are reset, not left uninitialised: the display must come up
  // blank (digit_en all zero) and pending data must be discarded by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      shadow     <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      if (load)            shadow <= in_buf;
      else if (pend_valid) shadow <= pend;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend       <= in_buf;
      pend_valid <= 1'b1;
    end
  end

  logic [3:0]            cur_hex;
  logic                  upper_zero, lz_blank, hard_blank, lit;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  // NOTE: every signal gets a value on every path of this block, so no latches.
  always_comb begin
    cur_hex    = shadow.digits[4*int'(idx) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && shadow.digits[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    lz_blank   = shadow.lz && (idx != '0) && upper_zero;
    hard_blank = !shadow.en[idx] || (shadow.blink[idx] && blink_ph);
    // A zero-suppressed digit still drives its anode when it owns a decimal point.
    lit        = !dead && !hard_blank && (!lz_blank || shadow.dp[idx]);
    an_d       = lit ? (NUM_DIGITS'(1) << idx) : '0;
    seg_d      = (lit && !lz_blank) ? seg_decode(cur_hex) : SEG_BLANK;
    dp_d       = lit && shadow.dp[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '0;
      seg         <= SEG_BLANK;
      seg_dp      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      seg_dp      <= dp_d;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench: cycle-count model of the scanner compared every cycle,
// plus directed scenarios with literal expectations.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FRAME = SD * ND;

  localparam logic [6:0] DEC [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits = '0;
  logic [3:0]    dp = '0, digit_en = '0, blink_mask = '0;
  logic          lz_suppress = 1'b0, load = 1'b0;
  logic [6:0]    seg;
  logic          seg_dp;
  logic [3:0]    an;
  logic          frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
    .blink_mask(blink_mask), .lz_suppress(lz_suppress), .load(load),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state is derived from the number of clock edges since reset release.
  int          m_n;
  logic [15:0] m_sh_d, m_pe_d;
  logic [3:0]  m_sh_dp, m_sh_en, m_sh_bm, m_pe_dp, m_pe_en, m_pe_bm;
  logic        m_sh_lz, m_pe_lz, m_pe_v;
  logic [3:0]  exp_an = '0;
  logic [6:0]  exp_seg = '0;
  logic        exp_dp = 1'b0, exp_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int c, d, fr;
    bit ph, lzb, blk;
    if (!rst_n) begin
      m_n = 0;
      {m_sh_d, m_pe_d} = '0;
      {m_sh_dp, m_sh_en, m_sh_bm, m_pe_dp, m_pe_en, m_pe_bm} = '0;
      {m_sh_lz, m_pe_lz, m_pe_v} = '0;
      exp_an = '0; exp_seg = '0; exp_dp = 1'b0; exp_fs = 1'b0;
    end else begin
      c   = m_n % SD;
      d   = (m_n / SD) % ND;
      fr  = m_n / FRAME;
      ph  = ((fr / BF) % 2) == 1;
      lzb = m_sh_lz && d != 0 && ((m_sh_d >> (4 * d)) == 16'h0);
      blk = (c < DC) || !m_sh_en[d] || (m_sh_bm[d] && ph) || (lzb && !m_sh_dp[d]);
      exp_an  = blk ? 4'b0 : (4'b1 << d);
      exp_seg = (blk || lzb) ? 7'h0 : DEC[m_sh_d[4*d +: 4]];
      exp_dp  = !blk && m_sh_dp[d];
      exp_fs  = (m_n % FRAME) == FRAME - 1;
      if (exp_fs) begin
        if (load) begin
          m_sh_d = digits; m_sh_dp = dp; m_sh_en = digit_en; m_sh_bm = blink_mask; m_sh_lz = lz_suppress;
        end else if (m_pe_v) begin
          m_sh_d = m_pe_d; m_sh_dp = m_pe_dp; m_sh_en = m_pe_en; m_sh_bm = m_pe_bm; m_sh_lz = m_pe_lz;
        end
        m_pe_v = 1'b0;
      end else if (load) begin
        m_pe_d = digits; m_pe_dp = dp; m_pe_en = digit_en; m_pe_bm = blink_mask; m_pe_lz = lz_suppress;
        m_pe_v = 1'b1;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    check("model_an", 32'(an), 32'(exp_an));
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_dp", 32'(seg_dp), 32'(exp_dp));
    check("model_frame_start", 32'(frame_start), 32'(exp_fs));
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fs();
    int i;
    @(negedge clk);
    for (i = 0; i < 100 && frame_start !== 1'b1; i++) @(negedge clk);
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                         input logic [3:0] b, input logic lz);
    digits = d; dp = p; digit_en = e; blink_mask = b; lz_suppress = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic expect_pins(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
    check({name, "_an"}, 32'(an), 32'(a));
    check({name, "_seg"}, 32'(seg), 32'(s));
    check({name, "_dp"}, 32'(seg_dp), 32'(p));
  endtask

  logic vis [4];
  int   nz;

  initial begin
    rst_n = 1'b0;
    step(3);
    expect_pins("reset", 4'h0, 7'h00, 1'b0);
    check("reset_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;

    // 1: reset and first commit
    do_load(16'h1234, 4'h0, 4'hF, 4'h0, 1'b0);
    for (int i = 0; i < 100 && frame_start !== 1'b1; i++) begin
      check("pre_commit_an", 32'(an), 32'd0);
      @(negedge clk);
    end
    check("first_fs", 32'(frame_start), 32'd1);
    step(2);  expect_pins("first_d0", 4'b0001, 7'h33, 1'b0);
    step(4);  expect_pins("first_d1", 4'b0010, 7'h79, 1'b0);

    // 2: dead time across one full frame
    wait_fs();
    for (int k = 1; k <= FRAME; k++) begin
      step(1);
      if (k % SD == 1) begin
        check("dead_an", 32'(an), 32'd0);
        check("dead_seg", 32'(seg), 32'd0);
      end else begin
        check("live_an", 32'(an), 32'(4'b1 << ((k - 1) / SD)));
      end
    end

    // 3: mid-frame load, then load on the wrap tick
    step(6);
    do_load(16'hABCD, 4'h0, 4'hF, 4'h0, 1'b0);
    step(3);  expect_pins("midload_d2", 4'b0100, 7'h6D, 1'b0);
    step(4);  expect_pins("midload_d3", 4'b1000, 7'h30, 1'b0);
    wait_fs();
    step(2);  expect_pins("midload_new_d0", 4'b0001, 7'h3D, 1'b0);
    step(13);
    do_load(16'h5678, 4'h0, 4'hF, 4'h0, 1'b0);
    check("wrapload_fs", 32'(frame_start), 32'd1);
    step(2);  expect_pins("wrapload_d0", 4'b0001, 7'h7F, 1'b0);

    // 4: leading-zero suppression with a decimal point on a suppressed digit
    do_load(16'h0050, 4'b0100, 4'hF, 4'h0, 1'b1);
    wait_fs();
    step(2);  expect_pins("lz_d0", 4'b0001, 7'h7E, 1'b0);
    step(4);  expect_pins("lz_d1", 4'b0010, 7'h5B, 1'b0);
    step(4);  expect_pins("lz_d2", 4'b0100, 7'h00, 1'b1);
    step(4);  expect_pins("lz_d3", 4'b0000, 7'h00, 1'b0);

    // 5: blink on digit 0 only
    do_load(16'h1234, 4'h0, 4'hF, 4'b0001, 1'b0);
    wait_fs();
    nz = 0;
    for (int f = 0; f < 4; f++) begin
      step(2);
      vis[f] = (an == 4'b0001);
      if (vis[f]) nz++;
      step(4);
      expect_pins("blink_d1", 4'b0010, 7'h79, 1'b0);
      step(10);
    end
    check("blink_visible_frames", 32'(nz), 32'd2);
    check("blink_half_period_a", 32'(vis[0] != vis[2]), 32'd1);
    check("blink_half_period_b", 32'(vis[1] != vis[3]), 32'd1);

    // 6: reset mid-slot with a load pending
    do_load(16'hABCD, 4'h0, 4'hF, 4'h0, 1'b0);
    step(9);
    check("pre_reset_an", 32'(an), 32'b0100);
    #2 rst_n = 1'b0;
    #1 expect_pins("async_reset", 4'h0, 7'h00, 1'b0);
    check("async_reset_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1);
      if (an != 4'h0) nz++;
    end
    check("post_reset_blank", 32'(nz), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
